// File: rtl/mips_boot_loader_if.sv
// mips_boot_loader_if: host byte stream, instruction-memory write port and
// CPU reset/status lines of the boot loader, bundled as one interface.
// master = host / test side, slave = loader.
interface mips_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic              boot_start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [7:0]        im_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  modport master (
    output boot_start, in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err
  );

  modport slave (
    input  boot_start, in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err
  );
endinterface

// File: rtl/mips_boot_loader.sv
// mips_boot_loader: receives a length-prefixed byte image over valid/ready,
// writes it byte by byte (little-endian, no reordering) into instruction
// memory starting at BASE_ADDR and holds the CPU in reset until the image
// is loaded.
// Optional feature macro BOOT_CHKSUM_EN: when defined, a trailing XOR
// checksum byte is checked (CHK/ERR states, err output); when undefined the
// load ends right after the last payload byte and err is tied low.
module mips_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input logic               clk,
  input logic               rst,
  mips_boot_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
`ifdef BOOT_CHKSUM_EN
    CHK    = 3'd4,
    ERR    = 3'd6,
`endif
    DONE   = 3'd5
  } state_t;

  // State reached once the payload has been fully received.
`ifdef BOOT_CHKSUM_EN
  localparam state_t POST_DATA = CHK;
`else
  localparam state_t POST_DATA = DONE;
`endif

  state_t            state_r;
  state_t            next_s;
  logic [15:0]       len_r;
  logic [15:0]       idx_r;
  logic [ADDR_W-1:0] addr_r;
  logic              xfer_s;
  logic              len_zero_s;
  logic              last_s;
  logic              ready_next_s;
  logic              release_s;
`ifdef BOOT_CHKSUM_EN
  logic [7:0]        chk_r;
`endif

  assign xfer_s     = bus.in_valid && bus.in_ready;
  assign len_zero_s = ({bus.in_data, len_r[7:0]} == 16'h0000);
  assign last_s     = (idx_r == (len_r - 16'd1));

  // Release the CPU only once DONE is reached and no write is still in
  // flight: entering DONE straight from DATA leaves the final byte's write
  // strobe in the next cycle, so release waits one more cycle then.
  assign release_s  = (next_s == DONE) && (state_r != DATA);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.boot_start) next_s = LEN_LO;
        else                next_s = IDLE;
      end
      LEN_LO: begin
        if (xfer_s) next_s = LEN_HI;
        else        next_s = LEN_LO;
      end
      LEN_HI: begin
        if (xfer_s) begin
          if (len_zero_s) next_s = POST_DATA;
          else            next_s = DATA;
        end else begin
          next_s = LEN_HI;
        end
      end
      DATA: begin
        if (xfer_s && last_s) next_s = POST_DATA;
        else                  next_s = DATA;
      end
`ifdef BOOT_CHKSUM_EN
      CHK: begin
        if (xfer_s) begin
          if (bus.in_data == chk_r) next_s = DONE;
          else                      next_s = ERR;
        end else begin
          next_s = CHK;
        end
      end
      ERR: begin
        if (bus.boot_start) next_s = LEN_LO;
        else                next_s = ERR;
      end
`endif
      DONE: begin
        if (bus.boot_start) next_s = LEN_LO;
        else                next_s = DONE;
      end
      default: next_s = IDLE;
    endcase
  end

  // The loader accepts bytes in every state that expects stream input.
  always_comb begin
    ready_next_s = 1'b0;
    case (next_s)
      LEN_LO, LEN_HI, DATA: ready_next_s = 1'b1;
`ifdef BOOT_CHKSUM_EN
      CHK:                  ready_next_s = 1'b1;
`endif
      default:              ready_next_s = 1'b0;
    endcase
  end

  // Length, byte index, address counter and running checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r  <= 16'h0000;
      idx_r  <= 16'h0000;
      addr_r <= '0;
`ifdef BOOT_CHKSUM_EN
      chk_r  <= 8'h00;
`endif
    end else begin
      case (state_r)
        LEN_LO: begin
          if (xfer_s) len_r[7:0] <= bus.in_data;
        end
        LEN_HI: begin
          if (xfer_s) begin
            len_r[15:8] <= bus.in_data;
            idx_r       <= 16'h0000;
            addr_r      <= BASE;
`ifdef BOOT_CHKSUM_EN
            chk_r       <= 8'h00;
`endif
          end
        end
        DATA: begin
          if (xfer_s) begin
            idx_r  <= idx_r + 16'd1;
            addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef BOOT_CHKSUM_EN
            chk_r  <= chk_r ^ bus.in_data;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Registered instruction-memory write port: one strobe per payload byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= 8'h00;
    end else begin
      bus.im_we <= (state_r == DATA) && xfer_s;
      if ((state_r == DATA) && xfer_s) begin
        bus.im_addr  <= addr_r;
        bus.im_wdata <= bus.in_data;
      end
    end
  end

  // Registered handshake and status outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.in_ready <= 1'b0;
      bus.done     <= 1'b0;
      bus.cpu_rst  <= 1'b1;
    end else begin
      bus.in_ready <= ready_next_s;
      bus.done     <= release_s;
      bus.cpu_rst  <= !release_s;
    end
  end

`ifdef BOOT_CHKSUM_EN
  // Checksum error flag, held while parked in ERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.err <= 1'b0;
    end else begin
      bus.err <= (next_s == ERR);
    end
  end
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_boot_loader.sv
// tb_mips_boot_loader: scoreboard bench for mips_boot_loader. dut0 uses the
// default geometry, dut1 uses ADDR_W=4 / BASE_ADDR=14 for the wrap case.
// Expected writes are queued when a payload byte is accepted and popped when
// the matching im_we strobe appears.
module tb_mips_boot_loader;

  localparam int AW1   = 4;
  localparam int BASE1 = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       host_valid = 1'b0;
  logic [7:0] host_data = 8'h00;
  int         sel = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mips_boot_loader_if #(.ADDR_W(10))  bus0 ();
  mips_boot_loader_if #(.ADDR_W(AW1)) bus1 ();

  assign bus0.boot_start = start0;
  assign bus0.in_valid   = host_valid && (sel == 0);
  assign bus0.in_data    = host_data;
  assign bus1.boot_start = start1;
  assign bus1.in_valid   = host_valid && (sel == 1);
  assign bus1.in_data    = host_data;

  mips_boot_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mips_boot_loader #(.ADDR_W(AW1), .BASE_ADDR(BASE1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    int         addr;
    logic [7:0] data;
    int         due;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  wr0 = 0;
  int  wr1 = 0;

  function automatic logic rdy();
    return (sel == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  function automatic logic sdone();
    return (sel == 0) ? bus0.done : bus1.done;
  endfunction

  function automatic logic serr();
    return (sel == 0) ? bus0.err : bus1.err;
  endfunction

  function automatic logic scpu();
    return (sel == 0) ? bus0.cpu_rst : bus1.cpu_rst;
  endfunction

  // Advance to the next falling edge and score any write strobe seen there.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (bus0.im_we === 1'b1) begin
      wr0++;
      total_cnt++;
      if (q0.size() == 0) begin
        $display("FAIL wr0_unexpected: got addr=%0d data=%02h, expected no write",
                 bus0.im_addr, bus0.im_wdata);
      end else begin
        e = q0.pop_front();
        if (bus0.im_addr !== 10'(e.addr) || bus0.im_wdata !== e.data ||
            cyc != e.due || bus0.done !== 1'b0)
          $display("FAIL wr0: got addr=%0d data=%02h cyc=%0d done=%b, expected addr=%0d data=%02h cyc=%0d done=0",
                   bus0.im_addr, bus0.im_wdata, cyc, bus0.done, e.addr, e.data, e.due);
        else
          pass_cnt++;
      end
    end
    if (bus1.im_we === 1'b1) begin
      wr1++;
      total_cnt++;
      if (q1.size() == 0) begin
        $display("FAIL wr1_unexpected: got addr=%0d data=%02h, expected no write",
                 bus1.im_addr, bus1.im_wdata);
      end else begin
        e = q1.pop_front();
        if (bus1.im_addr !== 4'(e.addr) || bus1.im_wdata !== e.data ||
            cyc != e.due || bus1.done !== 1'b0)
          $display("FAIL wr1: got addr=%0d data=%02h cyc=%0d done=%b, expected addr=%0d data=%02h cyc=%0d done=0",
                   bus1.im_addr, bus1.im_wdata, cyc, bus1.done, e.addr, e.data, e.due);
        else
          pass_cnt++;
      end
    end
  endtask

  // Offer one byte; payload bytes push their expected write when accepted.
  task automatic send_byte(input logic [7:0] b, input bit pay, input int pidx);
    int  n;
    wr_t e;
    host_data  = b;
    host_valid = 1'b1;
    n = 0;
    while (rdy() !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (rdy() !== 1'b1) begin
      total_cnt++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, expected 1", rdy(), n);
      host_valid = 1'b0;
      return;
    end
    if (pay) begin
      e.addr = (sel == 0) ? (pidx % 1024) : ((BASE1 + pidx) % (1 << AW1));
      e.data = b;
      e.due  = cyc + 1;
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    tick();
    host_valid = 1'b0;
  endtask

  task automatic pulse_start();
    if (sel == 0) start0 = 1'b1;
    else          start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Full image: start, length, payload (optionally gapped), checksum.
  task automatic load(input logic [7:0] pay[$], input bit gap);
    logic [15:0] len;
    logic [7:0]  c;
    len = 16'(pay.size());
    c   = 8'h00;
    pulse_start();
    send_byte(len[7:0], 1'b0, 0);
    send_byte(len[15:8], 1'b0, 0);
    foreach (pay[i]) begin
      c = c ^ pay[i];
      send_byte(pay[i], 1'b1, i);
      if (gap) tick();
    end
`ifdef BOOT_CHKSUM_EN
    send_byte(c, 1'b0, 0);
`endif
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (sdone() !== 1'b1 && serr() !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({bus0.cpu_rst, bus0.in_ready, bus0.im_we, bus0.done, bus0.err} !== 5'b10000)
      $display("FAIL reset0: got cpu_rst/in_ready/im_we/done/err=%b, expected 10000",
               {bus0.cpu_rst, bus0.in_ready, bus0.im_we, bus0.done, bus0.err});
    else pass_cnt++;
    total_cnt++;
    if ({bus1.cpu_rst, bus1.in_ready, bus1.im_we, bus1.done, bus1.err} !== 5'b10000)
      $display("FAIL reset1: got %b, expected 10000",
               {bus1.cpu_rst, bus1.in_ready, bus1.im_we, bus1.done, bus1.err});
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total_cnt++;
    if ({bus0.cpu_rst, bus0.in_ready, bus0.im_we, bus0.done, bus0.err} !== 5'b10000)
      $display("FAIL idle_no_start: got %b, expected 10000",
               {bus0.cpu_rst, bus0.in_ready, bus0.im_we, bus0.done, bus0.err});
    else pass_cnt++;
  endtask

  task automatic test_normal_load();
    logic [7:0] pay[$];
    int w;
    sel = 0;
    w   = wr0;
    pay = '{8'h20, 8'h08, 8'h00, 8'h05};
    load(pay, 1'b0);
    wait_end();
    total_cnt++;
    if ({bus0.done, bus0.cpu_rst, bus0.err} !== 3'b100)
      $display("FAIL normal_done: got done/cpu_rst/err=%b, expected 100",
               {bus0.done, bus0.cpu_rst, bus0.err});
    else pass_cnt++;
    total_cnt++;
    if (q0.size() != 0 || (wr0 - w) != 4)
      $display("FAIL normal_writes: got %0d writes with %0d pending, expected 4 and 0",
               wr0 - w, q0.size());
    else pass_cnt++;
  endtask

`ifdef BOOT_CHKSUM_EN
  task automatic test_bad_checksum();
    logic [7:0] pay[$];
    sel = 0;
    pay = '{8'h20, 8'h08, 8'h00, 8'h05};
    pulse_start();
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    foreach (pay[i]) send_byte(pay[i], 1'b1, i);
    send_byte(8'h00, 1'b0, 0);
    wait_end();
    total_cnt++;
    if ({bus0.err, bus0.cpu_rst, bus0.done} !== 3'b110)
      $display("FAIL bad_chk: got err/cpu_rst/done=%b, expected 110",
               {bus0.err, bus0.cpu_rst, bus0.done});
    else pass_cnt++;
    load(pay, 1'b0);
    wait_end();
    total_cnt++;
    if ({bus0.err, bus0.cpu_rst, bus0.done} !== 3'b001)
      $display("FAIL bad_chk_recover: got err/cpu_rst/done=%b, expected 001",
               {bus0.err, bus0.cpu_rst, bus0.done});
    else pass_cnt++;
  endtask
`endif

  task automatic test_zero_length();
    int w;
    sel = 0;
    w   = wr0;
    pulse_start();
    total_cnt++;
    if ({bus0.done, bus0.cpu_rst, bus0.in_ready} !== 3'b011)
      $display("FAIL restart: got done/cpu_rst/in_ready=%b, expected 011",
               {bus0.done, bus0.cpu_rst, bus0.in_ready});
    else pass_cnt++;
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
`ifdef BOOT_CHKSUM_EN
    send_byte(8'h00, 1'b0, 0);
`endif
    wait_end();
    tick();
    total_cnt++;
    if ({bus0.done, bus0.cpu_rst, bus0.err} !== 3'b100)
      $display("FAIL zero_len_done: got done/cpu_rst/err=%b, expected 100",
               {bus0.done, bus0.cpu_rst, bus0.err});
    else pass_cnt++;
    total_cnt++;
    if (wr0 != w)
      $display("FAIL zero_len_writes: got %0d writes, expected 0", wr0 - w);
    else pass_cnt++;
  endtask

  task automatic test_wrap_backpressure();
    logic [7:0] pay[$];
    int w;
    sel = 1;
    w   = wr1;
    pay = '{8'hAA, 8'hBB, 8'hCC};
    load(pay, 1'b1);
    wait_end();
    total_cnt++;
    if ({bus1.done, bus1.cpu_rst, bus1.err} !== 3'b100)
      $display("FAIL wrap_done: got done/cpu_rst/err=%b, expected 100",
               {bus1.done, bus1.cpu_rst, bus1.err});
    else pass_cnt++;
    total_cnt++;
    if (q1.size() != 0 || (wr1 - w) != 3)
      $display("FAIL wrap_writes: got %0d writes with %0d pending, expected 3 and 0",
               wr1 - w, q1.size());
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [7:0] pay[$];
    sel = 0;
    pulse_start();
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 1);
    tick();
    total_cnt++;
    if (q0.size() != 0 || bus0.in_ready !== 1'b1)
      $display("FAIL mid_data: got pending=%0d in_ready=%b, expected 0 and 1",
               q0.size(), bus0.in_ready);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus0.cpu_rst, bus0.in_ready, bus0.im_we, bus0.done} !== 4'b1000)
      $display("FAIL async_rst: got cpu_rst/in_ready/im_we/done=%b, expected 1000",
               {bus0.cpu_rst, bus0.in_ready, bus0.im_we, bus0.done});
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({bus0.cpu_rst, bus0.in_ready} !== 2'b10)
      $display("FAIL rst_idle: got cpu_rst/in_ready=%b, expected 10",
               {bus0.cpu_rst, bus0.in_ready});
    else pass_cnt++;
    pay = '{8'h33, 8'h44, 8'h55, 8'h66};
    load(pay, 1'b0);
    wait_end();
    total_cnt++;
    if ({bus0.done, bus0.cpu_rst} !== 2'b10 || q0.size() != 0)
      $display("FAIL reload: got done/cpu_rst=%b pending=%0d, expected 10 and 0",
               {bus0.done, bus0.cpu_rst}, q0.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_normal_load();
`ifdef BOOT_CHKSUM_EN
    test_bad_checksum();
`endif
    test_zero_length();
    test_wrap_backpressure();
    test_async_reset();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
- Writer side of the single-cycle CPU's byte-wide instruction memory: accepts a length-prefixed byte stream over a valid/ready handshake and writes it little-endian into instruction memory, one byte per write.
- Holds the CPU in reset until the image is fully loaded and verified, then releases it.
- Replaces file preloading with a hardware load path.
- Sits between a host byte source and the instruction-memory write port / CPU reset.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width; the address counter wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, byte address of the first payload byte.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- boot_start  input  1  one-cycle pulse; starts or restarts a load.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction-memory byte write strobe.
- im_addr  output  ADDR_W  write byte address.
- im_wdata  output  8  write byte.
- cpu_rst  output  1  reset to the CPU, active-high.
- done  output  1  load completed successfully (level).
- err  output  1  checksum mismatch (level).

Behaviour:
- Reset values: in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rst=1, done=0, err=0; FSM in IDLE.
- Reset is asynchronous. Asserting rst mid-load abandons the load, returns to IDLE and raises cpu_rst immediately.
- A byte transfer occurs on a rising edge where in_valid && in_ready.
- in_ready is a registered function of state: 1 in LEN_LO, LEN_HI, DATA, CHK; 0 otherwise.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
- IDLE: boot_start -> LEN_LO.
- LEN_LO: transfer latches len[7:0] -> LEN_HI.
- LEN_HI: transfer latches len[15:8]; if {in_data, len[7:0]}==0, go to CHK, else DATA. Set idx=0 and chk=0.
- DATA: each transfer schedules a write; idx increments; chk ^= in_data. After the transfer with idx==len-1, go to CHK.
- CHK: transfer compares in_data with chk; equal -> DONE, else -> ERR. For len==0 the expected checksum is 0x00.
- DONE: done=1, cpu_rst=0. boot_start -> LEN_LO with done=0 and cpu_rst=1 the next cycle.
- ERR: err=1, cpu_rst stays 1. boot_start -> LEN_LO with err=0.
- cpu_rst is 1 in every state except DONE.
- boot_start outside IDLE/DONE/ERR is ignored.
- Write timing: a DATA transfer at edge N drives im_we=1, im_addr=(BASE_ADDR+idx) mod 2^ADDR_W and im_wdata=in_data during cycle N+1 (registered). im_we is a single-cycle pulse per byte; back-to-back transfers give back-to-back writes.
- Addresses wrap past 2^ADDR_W-1 to 0 without error.
- done rises no earlier than the cycle after the last write's im_we cycle, so the CPU never fetches a stale final byte.
- Byte order: the host sends instruction bytes LSB first, matching the little-endian instruction memory. The loader does not reorder bytes.
- in_valid with in_ready=0 is not consumed. The host must hold data stable until accepted.

Optional Feature:
- Macro: BOOT_CHKSUM_EN.
- Defined: CHK state present, err/ERR behave as above.
- Undefined: no CHK state and no checksum byte. After the last DATA byte (or after LEN_HI when len==0) go directly to DONE. err is tied 0.

Test Plan:
- Reset: rst=1 -> cpu_rst=1, in_ready=0, im_we=0, done=0, err=0. Release rst with no start -> state unchanged.
- Normal load: start; send 04 00, 20 08 00 05, chk 0x2D. Expect writes addr0=20, addr1=08, addr2=00, addr3=05, each one cycle after its accept. Then done=1, cpu_rst=0.
- Bad checksum: same payload, chk 0x00 -> ERR, err=1, cpu_rst stays 1. Then start plus a correct image -> err clears, done=1.
- Zero length: send 00 00, chk 00 -> no im_we, done=1.
- Wrap and backpressure: ADDR_W=4, BASE_ADDR=14, len=3, in_valid toggled every other cycle. Expect addresses 14, 15, 0; in_valid-low cycles produce no writes.
- Async reset mid-DATA after 2 of 4 bytes: cpu_rst=1 without waiting for a clock edge, state IDLE. A restart reloads from BASE_ADDR.
